// File: rtl/caravel_ips_wb_bus.sv
// caravel_ips_wb_bus: Wishbone fabric behind the management-SoC slave port.
// Takes one classic-cycle request at a time and routes it by address to one
// of NSLV peripheral slots. Every transfer has a timeout. Unmapped or hung
// slots get a fixed error word. An error-status register sits at slot 15,
// and err_irq_o raises an interrupt while an error is pending.

module caravel_ips_wb_bus #(
    parameter int          NSLV     = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NSLV-1:0]      m_cyc_o,
    output logic [NSLV-1:0]      m_stb_o,
    output logic                 m_we_o,
    output logic [3:0]           m_sel_o,
    output logic [15:0]          m_adr_o,
    output logic [31:0]          m_dat_o,
    input  logic [NSLV*32-1:0]   m_dat_i,
    input  logic [NSLV-1:0]      m_ack_i,
    output logic                 err_irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [4:0] NSLV_W  = 5'(NSLV);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] STATUS_SLOT = 4'hF;

    state_t state, state_nx;

    // Latched request fields, held stable toward the slots for the whole access
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [15:0] lat_adr;
    logic [31:0] lat_dat;
    logic [3:0]  slot_q;

    logic [7:0]      to_cnt;
    logic [31:0]     resp_q;
    logic [NSLV-1:0] stb_q;

    logic [7:0] err_cnt;
    logic       err_pending;
    logic [3:0] last_err_slot;
    logic       last_err_to;

    // Request decode
    logic       req;
    logic [3:0] req_slot;
    logic       req_mapped;
    logic       req_status;
    logic       unused_adr_bits;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign req_slot   = wbs_adr_i[19:16];
    assign req_mapped = ({1'b0, req_slot} < NSLV_W);
    assign req_status = (req_slot == STATUS_SLOT);
    assign unused_adr_bits = &wbs_adr_i[31:20];

    logic [31:0] status_word;
    assign status_word = {err_cnt, 4'b0, last_err_slot, 7'b0, last_err_to, 7'b0, err_pending};

    // FSM control strobes produced by the next-state logic
    logic        latch_req;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        ld_resp;
    logic [31:0] resp_nx;
    logic        err_event;
    logic        err_to;
    logic [3:0]  err_slot;
    logic        clr_status;
    logic [3:0]  slot_nx;
    logic [NSLV-1:0] stb_nx;

    // Selected slot's ack and read data
    logic        sel_ack;
    logic [31:0] sel_dat;

    // Mux the active slot's ack and read data out of the flattened slot buses
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (slot_q == 4'(k)) begin
                sel_ack = m_ack_i[k];
                sel_dat = m_dat_i[32*k +: 32];
            end
        end
    end

    // State register; reset returns to IDLE at once so a live access is dropped
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the per-cycle datapath control strobes
    always_comb begin
        state_nx   = state;
        latch_req  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ld_resp    = 1'b0;
        resp_nx    = resp_q;
        err_event  = 1'b0;
        err_to     = 1'b0;
        err_slot   = slot_q;
        clr_status = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    latch_req = 1'b1;
                    if (req_mapped) begin
                        state_nx = ST_ACCESS;
                        cnt_clr  = 1'b1;
                    end else if (req_status) begin
                        state_nx   = ST_RESP;
                        ld_resp    = 1'b1;
                        resp_nx    = wbs_we_i ? 32'h0 : status_word;
                        clr_status = wbs_we_i & wbs_sel_i[0] & wbs_dat_i[0];
                    end else begin
                        state_nx  = ST_RESP;
                        ld_resp   = 1'b1;
                        resp_nx   = ERR_DATA;
                        err_event = 1'b1;
                        err_to    = 1'b0;
                        err_slot  = req_slot;
                    end
                end
            end

            ST_ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_nx = ST_IDLE;
                end else if (sel_ack) begin
                    state_nx = ST_RESP;
                    ld_resp  = 1'b1;
                    resp_nx  = lat_we ? 32'h0 : sel_dat;
                end else if (to_cnt == TO_LAST) begin
                    state_nx  = ST_RESP;
                    ld_resp   = 1'b1;
                    resp_nx   = ERR_DATA;
                    err_event = 1'b1;
                    err_to    = 1'b1;
                    err_slot  = slot_q;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_RESP: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // One-hot strobe for the next cycle, so slot strobes come straight off flops
    always_comb begin
        slot_nx = latch_req ? req_slot : slot_q;
        stb_nx  = '0;
        for (int k = 0; k < NSLV; k++) begin
            if ((state_nx == ST_ACCESS) && (slot_nx == 4'(k))) begin
                stb_nx[k] = 1'b1;
            end
        end
    end

    // Request latches, timeout counter, response word and slot strobes
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            lat_we  <= 1'b0;
            lat_sel <= '0;
            lat_adr <= '0;
            lat_dat <= '0;
            slot_q  <= '0;
            to_cnt  <= '0;
            resp_q  <= '0;
            stb_q   <= '0;
        end else begin
            if (latch_req) begin
                lat_we  <= wbs_we_i;
                lat_sel <= wbs_sel_i;
                lat_adr <= wbs_adr_i[15:0];
                lat_dat <= wbs_dat_i;
                slot_q  <= req_slot;
            end
            if (cnt_clr) begin
                to_cnt <= '0;
            end else if (cnt_inc) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (ld_resp) begin
                resp_q <= resp_nx;
            end
            stb_q <= stb_nx;
        end
    end

    // Error bookkeeping: an error event records itself, a status write clears it
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            err_cnt       <= '0;
            err_pending   <= 1'b0;
            last_err_slot <= '0;
            last_err_to   <= 1'b0;
        end else if (err_event) begin
            err_pending   <= 1'b1;
            last_err_slot <= err_slot;
            last_err_to   <= err_to;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (clr_status) begin
            err_pending <= 1'b0;
            err_cnt     <= '0;
        end
    end

    assign wbs_ack_o = (state == ST_RESP);
    assign wbs_dat_o = wbs_ack_o ? resp_q : 32'h0;
    assign m_cyc_o   = stb_q;
    assign m_stb_o   = stb_q;
    assign m_we_o    = lat_we;
    assign m_sel_o   = lat_sel;
    assign m_adr_o   = lat_adr;
    assign m_dat_o   = lat_dat;
    assign err_irq_o = err_pending;

endmodule

// File: tb/tb_caravel_ips_wb_bus.sv
// tb_caravel_ips_wb_bus: drives master transfers into the fabric, plays the
// slave side, and compares against a transaction-level model of the routing,
// timeout and error-status rules.

module tb_caravel_ips_wb_bus;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic          wb_clk_i;
    logic          wb_rst_n;
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic [NS-1:0] m_cyc_o;
    logic [NS-1:0] m_stb_o;
    logic          m_we_o;
    logic [3:0]    m_sel_o;
    logic [15:0]   m_adr_o;
    logic [31:0]   m_dat_o;
    logic [NS*32-1:0] m_dat_i;
    logic [NS-1:0] m_ack_i;
    logic          err_irq_o;

    caravel_ips_wb_bus #(.NSLV(NS), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .m_cyc_o  (m_cyc_o),
        .m_stb_o  (m_stb_o),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack_i),
        .err_irq_o(err_irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int tests;
    int fails;

    // Reference model of the error-status register
    int         mdl_cnt;
    bit         mdl_pend;
    logic [3:0] mdl_slot;
    bit         mdl_to;

    // Expected transfer outcome
    int         exp_lat;
    int         exp_stbc;
    logic [31:0] exp_rdat;
    logic [3:0] exp_mask;

    // Observed transfer outcome
    int         obs_lat;
    int         obs_stbc;
    logic [31:0] obs_rdat;
    logic [3:0] obs_mask;
    logic [3:0] obs_cmask;
    logic [15:0] obs_adr;
    logic       obs_we;
    logic [3:0] obs_sel;
    logic [31:0] obs_wdat;
    logic       obs_ack2;
    logic [31:0] obs_dat2;

    function automatic logic [31:0] mdl_status();
        logic [7:0] c;
        c = 8'(mdl_cnt);
        return {c, 4'b0, mdl_slot, 7'b0, mdl_to, 7'b0, mdl_pend};
    endfunction

    task automatic mdl_reset();
        mdl_cnt  = 0;
        mdl_pend = 0;
        mdl_slot = 4'h0;
        mdl_to   = 0;
    endtask

    task automatic mdl_error(input logic [3:0] s, input bit timed_out);
        mdl_pend = 1;
        if (mdl_cnt < 255) mdl_cnt++;
        mdl_slot = s;
        mdl_to   = timed_out;
    endtask

    // Predict latency, data and strobe footprint of one transfer from the rules
    task automatic mdl_xfer(input logic we_v, input logic [3:0] sel_v, input logic [31:0] adr_v,
                            input logic [31:0] dat_v, input int wait_n, input logic [31:0] sdat);
        int s;
        s = int'(adr_v[19:16]);
        if (s < NS) begin
            exp_mask = 4'(1 << s);
            if (wait_n <= TO - 1) begin
                exp_stbc = wait_n + 1;
                exp_lat  = wait_n + 2;
                exp_rdat = we_v ? 32'h0 : sdat;
            end else begin
                exp_stbc = TO;
                exp_lat  = TO + 1;
                exp_rdat = ERR;
                mdl_error(4'(s), 1);
            end
        end else if (s == 15) begin
            exp_mask = 4'h0;
            exp_stbc = 0;
            exp_lat  = 1;
            exp_rdat = we_v ? 32'h0 : mdl_status();
            if (we_v && sel_v[0] && dat_v[0]) begin
                mdl_pend = 0;
                mdl_cnt  = 0;
            end
        end else begin
            exp_mask = 4'h0;
            exp_stbc = 0;
            exp_lat  = 1;
            exp_rdat = ERR;
            mdl_error(4'(s), 0);
        end
    endtask

    // Master + slave driver; slave acks after wait_n wait cycles, others ack junk
    task automatic do_xfer(input logic we_v, input logic [3:0] sel_v, input logic [31:0] adr_v,
                           input logic [31:0] dat_v, input int wait_n, input logic [31:0] sdat);
        logic [3:0] s4;
        s4 = adr_v[19:16];
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we_v;
        wbs_sel_i = sel_v;
        wbs_adr_i = adr_v;
        wbs_dat_i = dat_v;
        m_ack_i   = '0;
        obs_lat = -1; obs_stbc = 0; obs_rdat = 'x; obs_mask = '0; obs_cmask = '0;
        obs_adr = 'x; obs_we = 'x; obs_sel = 'x; obs_wdat = 'x;
        for (int c = 1; c <= TO + 20; c++) begin
            @(negedge wb_clk_i);
            m_ack_i = '0;
            for (int k = 0; k < NS; k++) m_dat_i[32*k +: 32] = $urandom;
            if (wbs_ack_o) begin
                obs_lat  = c;
                obs_rdat = wbs_dat_o;
                break;
            end
            if (m_stb_o != '0) begin
                if (obs_stbc == 0) begin
                    obs_adr = m_adr_o; obs_we = m_we_o; obs_sel = m_sel_o; obs_wdat = m_dat_o;
                end
                obs_stbc++;
                obs_mask  = obs_mask | m_stb_o;
                obs_cmask = obs_cmask | m_cyc_o;
                if (int'(s4) < NS) begin
                    m_ack_i = 4'($urandom) & ~(4'b0001 << s4);
                    if (obs_stbc - 1 == wait_n) begin
                        m_ack_i[s4] = 1'b1;
                        m_dat_i[32*int'(s4) +: 32] = sdat;
                    end
                end
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_ack_i   = '0;
        @(negedge wb_clk_i);
        obs_ack2 = wbs_ack_o;
        obs_dat2 = wbs_dat_o;
    endtask

    task automatic xfer(input logic we_v, input logic [3:0] sel_v, input logic [31:0] adr_v,
                        input logic [31:0] dat_v, input int wait_n, input logic [31:0] sdat);
        mdl_xfer(we_v, sel_v, adr_v, dat_v, wait_n, sdat);
        do_xfer(we_v, sel_v, adr_v, dat_v, wait_n, sdat);
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        mdl_reset();
        #12;
        tests++;
        if ({wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, err_irq_o} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got ack=%b dat=%h cyc=%b stb=%b we=%b sel=%b adr=%h mdat=%h irq=%b exp all 0",
                     wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, err_irq_o);
        end
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat || obs_lat != exp_lat) begin
            fails++;
            $display("[TB] FAIL reset_status got %h lat %0d exp %h lat %0d", obs_rdat, obs_lat, exp_rdat, exp_lat);
        end
    endtask

    task automatic test_read_slot();
        xfer(1'b0, 4'hF, 32'h3002_0010, 32'h0, 0, 32'h1234_5678);
        tests++;
        if (obs_adr !== 16'h0010 || obs_mask !== 4'b0100 || obs_cmask !== 4'b0100 || obs_stbc != 1) begin
            fails++;
            $display("[TB] FAIL read_strobe got adr=%h stb=%b cyc=%b n=%0d exp adr=0010 stb=0100 cyc=0100 n=1",
                     obs_adr, obs_mask, obs_cmask, obs_stbc);
        end
        tests++;
        if (obs_lat != 2 || obs_rdat !== 32'h1234_5678) begin
            fails++;
            $display("[TB] FAIL read_ack got lat=%0d dat=%h exp lat=2 dat=12345678", obs_lat, obs_rdat);
        end
        tests++;
        if (obs_ack2 !== 1'b0 || obs_dat2 !== 32'h0) begin
            fails++;
            $display("[TB] FAIL read_single_ack got ack=%b dat=%h exp ack=0 dat=0", obs_ack2, obs_dat2);
        end
    endtask

    task automatic test_write_wait();
        xfer(1'b1, 4'b0011, 32'h0000_0040, 32'hA5A5_A5A5, 3, 32'h7777_7777);
        tests++;
        if (obs_we !== 1'b1 || obs_sel !== 4'b0011 || obs_wdat !== 32'hA5A5_A5A5 || obs_adr !== 16'h0040) begin
            fails++;
            $display("[TB] FAIL write_fields got we=%b sel=%b dat=%h adr=%h exp we=1 sel=0011 dat=a5a5a5a5 adr=0040",
                     obs_we, obs_sel, obs_wdat, obs_adr);
        end
        tests++;
        if (obs_stbc != 4 || obs_mask !== 4'b0001 || obs_lat != 5 || obs_rdat !== 32'h0 || obs_ack2 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL write_timing got n=%0d stb=%b lat=%0d dat=%h ack2=%b exp n=4 stb=0001 lat=5 dat=0 ack2=0",
                     obs_stbc, obs_mask, obs_lat, obs_rdat, obs_ack2);
        end
    endtask

    task automatic test_unmapped();
        xfer(1'b0, 4'hF, 32'h0005_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_lat != 1 || obs_rdat !== ERR || obs_mask !== 4'h0 || err_irq_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL unmapped got lat=%0d dat=%h stb=%b irq=%b exp lat=1 dat=%h stb=0000 irq=1",
                     obs_lat, obs_rdat, obs_mask, err_irq_o, ERR);
        end
        xfer(1'b0, 4'hF, 32'h000F_0004, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL unmapped_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_timeout();
        xfer(1'b0, 4'hF, 32'h0001_0020, 32'h0, NEVER, 32'h0);
        tests++;
        if (obs_stbc != TO || obs_mask !== 4'b0010 || obs_lat != TO + 1 || obs_rdat !== ERR) begin
            fails++;
            $display("[TB] FAIL timeout got n=%0d stb=%b lat=%0d dat=%h exp n=%0d stb=0010 lat=%0d dat=%h",
                     obs_stbc, obs_mask, obs_lat, obs_rdat, TO, TO + 1, ERR);
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL timeout_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_ack_at_limit();
        xfer(1'b0, 4'hF, 32'h0003_0008, 32'h0, TO - 1, 32'hCAFE_F00D);
        tests++;
        if (obs_stbc != TO || obs_lat != TO + 1 || obs_rdat !== 32'hCAFE_F00D) begin
            fails++;
            $display("[TB] FAIL ack_at_limit got n=%0d lat=%0d dat=%h exp n=%0d lat=%0d dat=cafef00d",
                     obs_stbc, obs_lat, obs_rdat, TO, TO + 1);
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL ack_at_limit_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_status_clear();
        xfer(1'b1, 4'b0001, 32'h000F_0000, 32'h0000_0001, 0, 32'h0);
        tests++;
        if (err_irq_o !== 1'b0 || obs_lat != 1) begin
            fails++;
            $display("[TB] FAIL clear_irq got irq=%b lat=%0d exp irq=0 lat=1", err_irq_o, obs_lat);
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL clear_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_abort();
        logic [3:0] seen_stb;
        logic [3:0] stb_after;
        logic       ack_seen;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h0001_0000;
        repeat (3) @(negedge wb_clk_i);
        seen_stb  = m_stb_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        stb_after = m_stb_o;
        ack_seen  = wbs_ack_o;
        repeat (6) begin
            @(negedge wb_clk_i);
            ack_seen = ack_seen | wbs_ack_o | (|m_stb_o);
        end
        tests++;
        if (seen_stb !== 4'b0010 || stb_after !== 4'b0000 || ack_seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort got stb=%b after=%b ack/stb_seen=%b exp 0010 0000 0",
                     seen_stb, stb_after, ack_seen);
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL abort_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] stb_before;
        logic [3:0] stb_rst;
        logic       ack_seen;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h0002_0000;
        repeat (2) @(negedge wb_clk_i);
        stb_before = m_stb_o;
        #2;
        wb_rst_n = 1'b0;
        mdl_reset();
        #1;
        stb_rst = m_stb_o | m_cyc_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        ack_seen  = wbs_ack_o;
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        repeat (5) begin
            @(negedge wb_clk_i);
            ack_seen = ack_seen | wbs_ack_o;
        end
        tests++;
        if (stb_before !== 4'b0100 || stb_rst !== 4'b0000 || ack_seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid got before=%b at_reset=%b ack=%b exp 0100 0000 0",
                     stb_before, stb_rst, ack_seen);
        end
        xfer(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1, 32'h0BAD_F00D);
        tests++;
        if (obs_lat != exp_lat || obs_rdat !== exp_rdat || obs_mask !== exp_mask) begin
            fails++;
            $display("[TB] FAIL after_reset_read got lat=%0d dat=%h stb=%b exp lat=%0d dat=%h stb=%b",
                     obs_lat, obs_rdat, obs_mask, exp_lat, exp_rdat, exp_mask);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 4'hF, 32'h0009_0000 | 32'($urandom_range(0, 16'hFFFF)), 32'h0, 0, 32'h0);
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat || obs_rdat[31:24] !== 8'hFF) begin
            fails++;
            $display("[TB] FAIL saturation got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    task automatic test_random();
        int          pick;
        int          w;
        logic [3:0]  s4;
        logic        we_v;
        logic [3:0]  sel_v;
        logic [31:0] adr_v;
        logic [31:0] dat_v;
        logic [31:0] sdat;
        for (int i = 0; i < 40; i++) begin
            pick  = $urandom_range(0, 7);
            s4    = (pick == 7) ? 4'hF : 4'(pick);
            we_v  = 1'($urandom);
            sel_v = 4'($urandom);
            adr_v = {12'($urandom), s4, 16'($urandom)};
            dat_v = $urandom;
            sdat  = $urandom;
            w     = $urandom_range(0, TO + 2);
            if (w >= TO) w = NEVER;
            xfer(we_v, sel_v, adr_v, dat_v, w, sdat);
            tests++;
            if (obs_lat != exp_lat || obs_rdat !== exp_rdat || obs_stbc != exp_stbc ||
                obs_mask !== exp_mask || obs_cmask !== exp_mask || obs_ack2 !== 1'b0 ||
                obs_dat2 !== 32'h0 || err_irq_o !== mdl_pend) begin
                fails++;
                $display("[TB] FAIL random[%0d] slot=%h we=%b w=%0d got lat=%0d dat=%h n=%0d stb=%b ack2=%b irq=%b exp lat=%0d dat=%h n=%0d stb=%b ack2=0 irq=%b",
                         i, s4, we_v, w, obs_lat, obs_rdat, obs_stbc, obs_mask, obs_ack2, err_irq_o,
                         exp_lat, exp_rdat, exp_stbc, exp_mask, mdl_pend);
            end
            if (int'(s4) < NS) begin
                tests++;
                if (obs_adr !== adr_v[15:0] || obs_we !== we_v || obs_sel !== sel_v || obs_wdat !== dat_v) begin
                    fails++;
                    $display("[TB] FAIL random_fields[%0d] got adr=%h we=%b sel=%b dat=%h exp adr=%h we=%b sel=%b dat=%h",
                             i, obs_adr, obs_we, obs_sel, obs_wdat, adr_v[15:0], we_v, sel_v, dat_v);
                end
            end
        end
        xfer(1'b0, 4'hF, 32'h000F_0000, 32'h0, 0, 32'h0);
        tests++;
        if (obs_rdat !== exp_rdat) begin
            fails++;
            $display("[TB] FAIL random_status got %h exp %h", obs_rdat, exp_rdat);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        m_dat_i   = '0;
        m_ack_i   = '0;
        test_reset();
        test_read_slot();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_ack_at_limit();
        test_status_clear();
        test_abort();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/caravel_ips_wb_bus.md
# caravel_ips_wb_bus

Wishbone fabric directly downstream of the management-SoC Wishbone slave port of the user project. Accepts one classic-cycle master request at a time and routes it to one of `NSLV` peripheral slots by address. Bounds every transfer with a timeout and returns a fixed error word for unmapped or hung slots. Exposes an error-status register and an error interrupt for the user IRQ lines.

## Interface
- `NSLV`, 4: number of peripheral slots, 1..15; slot index = `wbs_adr_i[19:16]`.
- `TIMEOUT`, 255: maximum ACCESS cycles without slave ack, 2..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error response.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_n` in 1: reset, asynchronous assert, active-low.
- `wbs_cyc_i` in 1: master cycle.
- `wbs_stb_i` in 1: master strobe.
- `wbs_we_i` in 1: master write enable.
- `wbs_sel_i` in 4: master byte selects.
- `wbs_adr_i` in 32: master byte address.
- `wbs_dat_i` in 32: master write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data; valid only while `wbs_ack_o`=1, otherwise 0.
- `m_cyc_o` out NSLV: per-slot cycle.
- `m_stb_o` out NSLV: per-slot strobe.
- `m_we_o` out 1: latched write enable.
- `m_sel_o` out 4: latched byte selects.
- `m_adr_o` out 16: latched `wbs_adr_i[15:0]`.
- `m_dat_o` out 32: latched write data.
- `m_dat_i` in NSLV*32: slot read data; slot k at bits [32k+31:32k].
- `m_ack_i` in NSLV: per-slot acknowledge.
- `err_irq_o` out 1: equals `err_pending`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: when `wbs_cyc_i & wbs_stb_i`, latch we/sel/adr/dat and decode slot `s`.
  - `s < NSLV`: go to ACCESS. Assert `m_cyc_o[s]` and `m_stb_o[s]` (registered), and clear the timeout counter.
  - `s == 15`: status access; go to RESP.
  - Otherwise unmapped: error event (timeout flag 0); data = `ERR_DATA`; go to RESP.
- ACCESS: only slot `s` strobes; all other bits stay 0.
  - `m_ack_i[s]`=1: capture `m_dat_i` slot `s` (writes: capture 0), drop strobes, go to RESP.
  - Counter reaches `TIMEOUT`-1 with no ack: error event (timeout flag 1); data = `ERR_DATA`; drop strobes; go to RESP.
  - If ack and timeout coincide, the ack wins.
  - If `wbs_cyc_i` drops: abort. Drop strobes, go to IDLE, no ack, no error event.
- RESP: `wbs_ack_o`=1 with captured data for exactly one cycle, then go to IDLE unconditionally.
- Status register (slot 15, any offset):
  - Read = {`err_cnt`[7:0], 4'b0, `last_err_slot`[3:0], 7'b0, `last_err_to`, 7'b0, `err_pending`}.
  - Write with `sel[0]`=1 and `dat[0]`=1 clears `err_pending` and `err_cnt`. The last-error fields are kept.
- Error event effects:
  - `err_pending` set to 1.
  - `err_cnt` +1, saturating at 255.
  - `last_err_slot` = `s`.
  - `last_err_to` = timeout flag.
- Address bits [31:20] are ignored.

## Timing
- Reset state: IDLE.
  - All outputs 0.
  - All latched fields 0.
  - `err_cnt`, `err_pending`, `last_err_slot` and `last_err_to` all 0.
- Latency, with request first sampled at edge E0:
  - Status or unmapped access: `wbs_ack_o` high in the cycle after E0.
  - Mapped slot: `m_stb_o` high in the cycle after E0. A slave acking in its first strobe cycle gives `wbs_ack_o` high 2 cycles after E0. Each slave wait cycle adds 1.
  - Timeout: strobe held exactly `TIMEOUT` cycles, then `wbs_ack_o` in the next cycle.
- A request whose strobe is still high in the cycle after RESP starts a new transfer; there are no back-to-back acks.
- `wbs_ack_o` is never asserted on two consecutive cycles.
- Reset during ACCESS: strobes drop asynchronously and no ack is ever issued for that transfer.

## Test plan
- Read slot 2 at 0x3002_0010; slave 2 acks in its first strobe cycle with 0x1234_5678 → `m_adr_o`=0x0010 and `m_stb_o`=4'b0100 for 1 cycle. `wbs_ack_o` arrives 2 cycles after request with `wbs_dat_o`=0x1234_5678.
- Write 0xA5A5_A5A5 with sel=4'b0011 to slot 0; slave waits 3 cycles → `m_we_o`=1, `m_sel_o`=4'b0011 and `m_dat_o`=0xA5A5_A5A5 held 4 strobe cycles. One-cycle ack follows.
- Read slot 5 (unmapped, NSLV=4) → ack 1 cycle after request with 0xDEAD_BEEF. `err_irq_o`=1. Status read = 0x0105_0001.
- Slot 1 never acks, TIMEOUT=8 → strobe high exactly 8 cycles, then ack with 0xDEAD_BEEF. Status read = 0x0201_0101 after a prior unmapped error.
- Write 1 to status register → `err_irq_o` falls. Status read = 0x0001_0100 (count cleared, last slot/flag kept).
- Drop `wbs_cyc_i` mid-ACCESS; separately, pulse `wb_rst_n` mid-ACCESS → strobes drop, no ack, `err_cnt` unchanged. A subsequent slot-0 read completes normally.
